// File: rtl/fpu_sched_pkg.sv
// Shared types for the FPU command scheduler: unit codes, FSM states,
// the buffered command record and the legality check applied at issue.
package fpu_sched_pkg;

    localparam logic [3:0] UNIT_FCLASS = 4'd0;
    localparam logic [3:0] UNIT_SINJ   = 4'd1;
    localparam logic [3:0] UNIT_CMP    = 4'd2;
    localparam logic [3:0] UNIT_MINMAX = 4'd3;
    localparam logic [3:0] UNIT_I2F    = 4'd4;
    localparam logic [3:0] UNIT_F2I    = 4'd5;
    localparam logic [3:0] UNIT_ADDSUB = 4'd6;
    localparam logic [3:0] UNIT_MUL    = 4'd7;
    localparam logic [3:0] UNIT_FMA    = 4'd8;
    localparam logic [3:0] UNIT_DIV    = 4'd9;
    localparam logic [3:0] UNIT_SQRT   = 4'd10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MC, RESP} state_t;

    typedef struct packed {
        logic [3:0]  unit;
        logic [1:0]  op;
        logic [2:0]  frm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // sign-inject and compare have only three sub-ops; op 3 is undefined for them
    function automatic logic is_illegal(input logic [3:0] unit, input logic [1:0] op);
        return (unit > UNIT_SQRT) ||
               (((unit == UNIT_SINJ) || (unit == UNIT_CMP)) && (op == 2'd3));
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO with registered pointers; the extra pointer MSB tells full from empty.
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 103
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Issues buffered FPU commands one at a time, waits for single-cycle or
// iterative completion and returns the result over a valid/ready port.
module fpu_op_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 64,
    parameter int NUM_UNITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_unit,
    input  logic [1:0]           cmd_op,
    input  logic [2:0]           cmd_frm,
    input  logic [31:0]          cmd_a,
    input  logic [31:0]          cmd_b,
    input  logic [31:0]          cmd_c,
    output logic [NUM_UNITS-1:0] fpu_valid_in,
    output logic [1:0]           fpu_op,
    output logic [2:0]           fpu_frm,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic [31:0]          fpu_c,
    input  logic [31:0]          fpu_result,
    input  logic [4:0]           fpu_exc,
    input  logic                 fpu_div_done,
    input  logic                 fpu_sqrt_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic [4:0]           res_exc,
    output logic                 res_illegal,
    output logic                 res_timeout,
    output logic [4:0]           fflags,
    input  logic                 fflags_clr,
    output logic                 busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    cmd_t             cur;
    cmd_t             fifo_in;
    cmd_t             fifo_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             cur_illegal;
    logic             mc_done;
    logic [CNT_W-1:0] cnt;

    assign fifo_in  = '{unit: cmd_unit, op: cmd_op, frm: cmd_frm, a: cmd_a, b: cmd_b, c: cmd_c};
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state != IDLE);
    assign cur_illegal = is_illegal(cur.unit, cur.op);
    assign mc_done     = (cur.unit == UNIT_DIV) ? fpu_div_done : fpu_sqrt_done;

    assign fpu_op  = cur.op;
    assign fpu_frm = cur.frm;
    assign fpu_a   = cur.a;
    assign fpu_b   = cur.b;
    assign fpu_c   = cur.c;

    // Enables are decoded from state so they fall the instant reset asserts.
    always_comb begin
        fpu_valid_in = '0;
        if (!rst && (state == ISSUE) && !cur_illegal)
            fpu_valid_in[cur.unit] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            cnt         <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_exc     <= '0;
            res_illegal <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur         <= fifo_out;
                        res_illegal <= 1'b0;
                        res_timeout <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_illegal) begin
                        res_data    <= '0;
                        res_exc     <= '0;
                        res_illegal <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= RESP;
                    end else if ((cur.unit == UNIT_DIV) || (cur.unit == UNIT_SQRT)) begin
                        cnt   <= '0;
                        state <= WAIT_MC;
                    end else begin
                        res_data  <= fpu_result;
                        res_exc   <= fpu_exc;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WAIT_MC: begin
                    // a done arriving on the final count still wins over the timeout
                    if (mc_done) begin
                        res_data  <= fpu_result;
                        res_exc   <= fpu_exc;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_data    <= '0;
                        res_exc     <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An exception delivered in the same cycle as a clear is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fflags <= '0;
        else
            fflags <= (fflags_clr ? 5'd0 : fflags) | ((res_valid && res_ready) ? res_exc : 5'd0);
    end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler with a small datapath stub and
// hand-computed expected results.
module tb_fpu_op_scheduler;

    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 64;
    localparam int NUM_UNITS = 11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3:0]           cmd_unit;
    logic [1:0]           cmd_op;
    logic [2:0]           cmd_frm;
    logic [31:0]          cmd_a, cmd_b, cmd_c;
    logic [NUM_UNITS-1:0] fpu_valid_in;
    logic [1:0]           fpu_op;
    logic [2:0]           fpu_frm;
    logic [31:0]          fpu_a, fpu_b, fpu_c;
    logic [31:0]          fpu_result;
    logic [4:0]           fpu_exc;
    logic                 fpu_div_done;
    logic                 fpu_sqrt_done;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_data;
    logic [4:0]           res_exc;
    logic                 res_illegal;
    logic                 res_timeout;
    logic [4:0]           fflags;
    logic                 fflags_clr;
    logic                 busy;

    always #5 clk = ~clk;

    fpu_op_scheduler #(
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT),
        .NUM_UNITS (NUM_UNITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_unit      (cmd_unit),
        .cmd_op        (cmd_op),
        .cmd_frm       (cmd_frm),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_c         (cmd_c),
        .fpu_valid_in  (fpu_valid_in),
        .fpu_op        (fpu_op),
        .fpu_frm       (fpu_frm),
        .fpu_a         (fpu_a),
        .fpu_b         (fpu_b),
        .fpu_c         (fpu_c),
        .fpu_result    (fpu_result),
        .fpu_exc       (fpu_exc),
        .fpu_div_done  (fpu_div_done),
        .fpu_sqrt_done (fpu_sqrt_done),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_exc       (res_exc),
        .res_illegal   (res_illegal),
        .res_timeout   (res_timeout),
        .fflags        (fflags),
        .fflags_clr    (fflags_clr),
        .busy          (busy)
    );

    // Datapath stub: either a fixed answer or a XOR of the held operands.
    logic        use_fixed;
    logic [31:0] fixed_result;
    logic [4:0]  fixed_exc;
    assign fpu_result = use_fixed ? fixed_result : (fpu_a ^ fpu_b);
    assign fpu_exc    = use_fixed ? fixed_exc : fpu_c[4:0];

    int checks = 0;
    int errors = 0;

    // Enable pulses are tallied at the edge that closes the issue cycle.
    int                   pulse_cnt = 0;
    logic [NUM_UNITS-1:0] last_en   = '0;
    always @(posedge clk) begin
        if (fpu_valid_in != '0) begin
            pulse_cnt = pulse_cnt + 1;
            last_en   = fpu_valid_in;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Offers one command from a falling edge and returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic [3:0] unit, input logic [1:0] op, input logic [2:0] frm,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic accepted;
        accepted  = 1'b0;
        cmd_unit  = unit;
        cmd_op    = op;
        cmd_frm   = frm;
        cmd_a     = a;
        cmd_b     = b;
        cmd_c     = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            accepted = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checkOutput("cmd_accept", 32'(accepted), 32'd1);
    endtask

    // lat is the cycle index of the first res_valid, counting the accept cycle as 0.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!res_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("res_valid_seen", 32'(res_valid), 32'd1);
    endtask

    task automatic takeResult(input logic clr);
        fflags_clr = clr;
        res_ready  = 1'b1;
        @(negedge clk);
        res_ready  = 1'b0;
        fflags_clr = 1'b0;
    endtask

    logic [3:0]  bp_unit [6] = '{4'd7, 4'd0, 4'd3, 4'd4, 4'd8, 4'd5};
    logic [31:0] bp_a    [6] = '{32'h1234_0000, 32'hFFFF_0000, 32'hA5A5_A5A5,
                                 32'h0F0F_0F0F, 32'h8000_0001, 32'hDEAD_0000};
    logic [31:0] bp_b    [6] = '{32'h0000_5678, 32'h00FF_00FF, 32'h5A5A_5A5A,
                                 32'h0000_0000, 32'h0000_0001, 32'h0000_BEEF};
    logic [31:0] bp_exp  [6] = '{32'h1234_5678, 32'hFF00_00FF, 32'hFFFF_FFFF,
                                 32'h0F0F_0F0F, 32'h8000_0000, 32'hDEAD_BEEF};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   lat;
        int   p0;
        int   n_acc;
        logic acc;
        logic seen;

        rst           = 1'b1;
        cmd_valid     = 1'b0;
        cmd_unit      = '0;
        cmd_op        = '0;
        cmd_frm       = '0;
        cmd_a         = '0;
        cmd_b         = '0;
        cmd_c         = '0;
        res_ready     = 1'b0;
        fflags_clr    = 1'b0;
        fpu_div_done  = 1'b0;
        fpu_sqrt_done = 1'b0;
        use_fixed     = 1'b0;
        fixed_result  = '0;
        fixed_exc     = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fflags", 32'(fflags), 32'd0);
        checkOutput("rst_valid_in", 32'(fpu_valid_in), 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] add: single-cycle issue and latency");
        use_fixed    = 1'b1;
        fixed_result = 32'h4040_0000;
        fixed_exc    = 5'b00000;
        p0 = pulse_cnt;
        applyStimulus(4'd6, 2'd0, 3'd0, 32'h3F80_0000, 32'h4000_0000, 32'd0);
        waitResult(lat);
        checkOutput("add_latency", 32'(lat), 32'd3);
        checkOutput("add_res_data", res_data, 32'h4040_0000);
        checkOutput("add_res_exc", 32'(res_exc), 32'd0);
        checkOutput("add_pulses", 32'(pulse_cnt - p0), 32'd1);
        checkOutput("add_enable", 32'(last_en), 32'h040);
        takeResult(1'b0);
        checkOutput("add_idle_busy", 32'(busy), 32'd0);

        $display("[TB] div: done after 12 cycles, foreign done ignored");
        fixed_result = 32'h7F80_0000;
        fixed_exc    = 5'b01000;
        applyStimulus(4'd9, 2'd0, 3'd0, 32'h3F80_0000, 32'h0000_0000, 32'd0);
        for (int k = 0; k < 10 && !fpu_valid_in[9]; k++) @(negedge clk);
        checkOutput("div_enable", 32'(fpu_valid_in), 32'h200);
        repeat (4) @(negedge clk);
        fpu_sqrt_done = 1'b1;
        @(negedge clk);
        fpu_sqrt_done = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("div_wait_no_valid", 32'(res_valid), 32'd0);
        checkOutput("div_wait_no_enable", 32'(fpu_valid_in), 32'd0);
        checkOutput("div_held_a", fpu_a, 32'h3F80_0000);
        fpu_div_done = 1'b1;
        @(negedge clk);
        fpu_div_done = 1'b0;
        checkOutput("div_res_valid", 32'(res_valid), 32'd1);
        checkOutput("div_res_data", res_data, 32'h7F80_0000);
        checkOutput("div_res_exc", 32'(res_exc), 32'b01000);
        takeResult(1'b0);
        checkOutput("div_fflags", 32'(fflags), 32'b01000);

        $display("[TB] fflags clear with concurrent exception");
        fixed_result = 32'h0000_0100;
        fixed_exc    = 5'b00001;
        applyStimulus(4'd0, 2'd0, 3'd0, 32'h0000_0001, 32'd0, 32'd0);
        waitResult(lat);
        checkOutput("clr_res_exc", 32'(res_exc), 32'b00001);
        takeResult(1'b1);
        checkOutput("clr_fflags", 32'(fflags), 32'b00001);

        $display("[TB] sqrt timeout then fclass");
        use_fixed = 1'b0;
        p0 = pulse_cnt;
        applyStimulus(4'd10, 2'd0, 3'd0, 32'h1111_0000, 32'h0000_2222, 32'd0);
        waitResult(lat);
        checkOutput("sqrt_to_latency", 32'(lat), 32'd67);
        checkOutput("sqrt_to_flag", 32'(res_timeout), 32'd1);
        checkOutput("sqrt_to_data", res_data, 32'd0);
        checkOutput("sqrt_to_exc", 32'(res_exc), 32'd0);
        checkOutput("sqrt_to_illegal", 32'(res_illegal), 32'd0);
        checkOutput("sqrt_to_enable", 32'(last_en), 32'h400);
        checkOutput("sqrt_to_pulses", 32'(pulse_cnt - p0), 32'd1);
        takeResult(1'b0);
        checkOutput("sqrt_to_fflags", 32'(fflags), 32'b00001);
        applyStimulus(4'd0, 2'd0, 3'd0, 32'h0000_FF00, 32'h0000_00FF, 32'h0000_0004);
        waitResult(lat);
        checkOutput("fclass_latency", 32'(lat), 32'd3);
        checkOutput("fclass_data", res_data, 32'h0000_FFFF);
        checkOutput("fclass_exc", 32'(res_exc), 32'b00100);
        checkOutput("fclass_timeout_clr", 32'(res_timeout), 32'd0);
        checkOutput("fclass_enable", 32'(last_en), 32'h001);
        takeResult(1'b0);
        checkOutput("fclass_fflags", 32'(fflags), 32'b00101);

        $display("[TB] illegal commands");
        p0 = pulse_cnt;
        applyStimulus(4'd2, 2'd3, 3'd0, 32'h1234_5678, 32'h0000_0001, 32'h0000_001F);
        waitResult(lat);
        checkOutput("cmp3_latency", 32'(lat), 32'd3);
        checkOutput("cmp3_illegal", 32'(res_illegal), 32'd1);
        checkOutput("cmp3_data", res_data, 32'd0);
        checkOutput("cmp3_exc", 32'(res_exc), 32'd0);
        checkOutput("cmp3_pulses", 32'(pulse_cnt - p0), 32'd0);
        takeResult(1'b0);
        applyStimulus(4'd13, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_001F);
        waitResult(lat);
        checkOutput("u13_illegal", 32'(res_illegal), 32'd1);
        checkOutput("u13_data", res_data, 32'd0);
        checkOutput("u13_pulses", 32'(pulse_cnt - p0), 32'd0);
        takeResult(1'b0);
        checkOutput("illegal_fflags", 32'(fflags), 32'b00101);
        applyStimulus(4'd1, 2'd2, 3'd0, 32'h0000_0F00, 32'h0000_00F0, 32'd0);
        waitResult(lat);
        checkOutput("sinj2_illegal", 32'(res_illegal), 32'd0);
        checkOutput("sinj2_data", res_data, 32'h0000_0FF0);
        checkOutput("sinj2_enable", 32'(last_en), 32'h002);
        takeResult(1'b0);

        $display("[TB] back-pressure with six commands");
        n_acc = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (n_acc < 6) begin
                cmd_unit  = bp_unit[n_acc];
                cmd_op    = 2'd0;
                cmd_frm   = 3'd0;
                cmd_a     = bp_a[n_acc];
                cmd_b     = bp_b[n_acc];
                cmd_c     = 32'(n_acc + 1);
                cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            acc = cmd_valid && cmd_ready;
            @(negedge clk);
            if (acc) n_acc++;
        end
        cmd_valid = 1'b0;
        checkOutput("bp_accepts", 32'(n_acc), 32'd5);
        checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("bp_busy", 32'(busy), 32'd1);
        waitResult(lat);
        checkOutput("bp_data0", res_data, bp_exp[0]);
        checkOutput("bp_exc0", 32'(res_exc), 32'd1);
        takeResult(1'b0);
        applyStimulus(bp_unit[5], 2'd0, 3'd0, bp_a[5], bp_b[5], 32'd6);
        for (int i = 1; i < 6; i++) begin
            waitResult(lat);
            checkOutput($sformatf("bp_data%0d", i), res_data, bp_exp[i]);
            checkOutput($sformatf("bp_exc%0d", i), 32'(res_exc), 32'(i + 1));
            takeResult(1'b0);
        end
        checkOutput("bp_fflags", 32'(fflags), 32'b00111);
        checkOutput("bp_drained_busy", 32'(busy), 32'd0);

        $display("[TB] reset during WAIT_MC");
        applyStimulus(4'd10, 2'd0, 3'd0, 32'hCAFE_0000, 32'h0000_0001, 32'd0);
        for (int k = 0; k < 10 && !fpu_valid_in[10]; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("wrst_valid_in", 32'(fpu_valid_in), 32'd0);
        checkOutput("wrst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("wrst_busy", 32'(busy), 32'd0);
        checkOutput("wrst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("wrst_fflags", 32'(fflags), 32'd0);
        checkOutput("wrst_fpu_a", fpu_a, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        use_fixed     = 1'b1;
        fixed_result  = 32'h1357_9BDF;
        fixed_exc     = 5'b10000;
        fpu_sqrt_done = 1'b1;
        @(negedge clk);
        fpu_sqrt_done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (res_valid || busy || (fpu_valid_in != '0)) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput("wrst_late_done_ignored", 32'(seen), 32'd0);
        checkOutput("wrst_res_data", res_data, 32'd0);
        checkOutput("wrst_fflags_after", 32'(fflags), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
